// File: rtl/sram_sdp_be.sv
// Single-clock simple-dual-port SRAM with byte enables, write-first reads and a post-reset clear sequencer.
// Define SRAM_PARITY_EN to store an even-parity bit per byte and report rd_perr on read.
module sram_sdp_be #(
  parameter int DEPTH          = 1024,
  parameter int WIDTH          = 4,
  parameter int READ_LATENCY   = 1,
  parameter bit CLEAR_ON_RESET = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_ce_b,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [WIDTH*8-1:0]       wr_data,
  input  logic [WIDTH-1:0]         wr_be,
  input  logic                     rd_ce_b,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [WIDTH*8-1:0]       rd_data,
  output logic                     rd_valid,
  output logic                     init_busy
`ifdef SRAM_PARITY_EN
  ,
  output logic                     rd_perr
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int DW = WIDTH * 8;
`ifdef SRAM_PARITY_EN
  localparam int BW = 9;
`else
  localparam int BW = 8;
`endif
  localparam int MW = WIDTH * BW;
  localparam logic [AW:0]   DEPTH_W = (AW + 1)'(DEPTH);
  localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);

  localparam logic [0:0] ST_INIT  = 1'b0;
  localparam logic [0:0] ST_READY = 1'b1;

  function automatic logic [MW-1:0] encode_word(input logic [DW-1:0] d);
    logic [MW-1:0] w;
    w = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w[i*BW +: 8] = d[i*8 +: 8];
`ifdef SRAM_PARITY_EN
      w[i*BW + 8] = ^d[i*8 +: 8];
`endif
    end
    return w;
  endfunction

  function automatic logic [DW-1:0] decode_word(input logic [MW-1:0] w);
    logic [DW-1:0] d;
    d = '0;
    for (int i = 0; i < WIDTH; i++) d[i*8 +: 8] = w[i*BW +: 8];
    return d;
  endfunction

`ifdef SRAM_PARITY_EN
  function automatic logic parity_err(input logic [MW-1:0] w);
    logic e;
    e = 1'b0;
    for (int i = 0; i < WIDTH; i++) e = e | (^w[i*BW +: BW]);
    return e;
  endfunction
`endif

  logic [0:0]    state;
  logic [AW-1:0] clr_cnt;
  logic          wr_ok;
  logic          rd_ok;
  logic [MW-1:0] wr_word;
  logic [MW-1:0] mem [DEPTH];

  logic          vld_p0;
  logic          inr_p0;
  logic [AW-1:0] addr_p0;
  logic          vld_p1;
  logic [MW-1:0] word_p1;
  logic          vld_out;
  logic [MW-1:0] word_out;

  assign init_busy = (state == ST_INIT);
  assign wr_ok     = !init_busy && !wr_ce_b && ({1'b0, wr_addr} < DEPTH_W);
  assign rd_ok     = !init_busy && !rd_ce_b;
  assign wr_word   = encode_word(wr_data);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= CLEAR_ON_RESET ? ST_INIT : ST_READY;
      clr_cnt <= '0;
    end else if (state == ST_INIT) begin
      if (clr_cnt == LAST) begin
        clr_cnt <= '0;
        state   <= ST_READY;
      end else begin
        clr_cnt <= clr_cnt + 1'b1;
      end
    end
  end

  // All-zero words carry even parity, so the clear pattern needs no encoding.
  always_ff @(posedge clk) begin
    if (init_busy) begin
      mem[clr_cnt] <= '0;
    end else if (wr_ok) begin
      for (int i = 0; i < WIDTH; i++)
        if (wr_be[i]) mem[wr_addr][i*BW +: BW] <= wr_word[i*BW +: BW];
    end
  end

  // Stage p0: request capture. The array is read one edge later, after a same-cycle write has landed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) vld_p0 <= 1'b0;
    else     vld_p0 <= rd_ok;
  end

  always_ff @(posedge clk) begin
    if (rd_ok) begin
      addr_p0 <= rd_addr;
      inr_p0  <= ({1'b0, rd_addr} < DEPTH_W);
    end
  end

  // Stage p1: array read; this is the output register when READ_LATENCY is 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      word_p1 <= '0;
    end else begin
      vld_p1 <= vld_p0;
      if (vld_p0) word_p1 <= inr_p0 ? mem[addr_p0] : '0;
    end
  end

  generate
    if (READ_LATENCY == 2) begin : g_lat2
      logic          vld_p2;
      logic [MW-1:0] word_p2;

      // Stage p2: extra output register.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          vld_p2  <= 1'b0;
          word_p2 <= '0;
        end else begin
          vld_p2 <= vld_p1;
          if (vld_p1) word_p2 <= word_p1;
        end
      end

      assign vld_out  = vld_p2;
      assign word_out = word_p2;
    end else begin : g_lat1
      assign vld_out  = vld_p1;
      assign word_out = word_p1;
    end
  endgenerate

  assign rd_data  = decode_word(word_out);
  assign rd_valid = vld_out;
`ifdef SRAM_PARITY_EN
  assign rd_perr  = vld_out && parity_err(word_out);
`endif

endmodule
